// File: rtl/pipe_pkg.sv
// Shared pipeline widths and control bundles used by the MEM stage and its memory.
package pipe_pkg;
  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef struct packed {
    logic RegWr;
    logic MemWr;
    logic MemtoReg;
    logic Branch;
  } mem_ctrl_t;

  typedef struct packed {
    logic RegWr;
    logic MemtoReg;
  } wb_ctrl_t;
endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM stage bundle plus the MEM stage results (branch, forwarding, MEM/WB).
interface mem_stage_if;
  import pipe_pkg::*;
  logic              mem_Zero, mem_Branch;
  logic [WORD_W-1:0] mem_target, mem_alu_result, mem_busB;
  logic [REG_W-1:0]  mem_Rw;
  logic              mem_RegWr, mem_MemWr, mem_MemtoReg;
  logic              PCSrc;
  logic [WORD_W-1:0] pc_target, fwd_mem_data;
  logic              fwd_mem_RegWr;
  logic [WORD_W-1:0] wb_alu_result, wb_mem_data;
  logic [REG_W-1:0]  wb_Rw;
  logic              wb_RegWr, wb_MemtoReg, mem_err;

  modport master (
    output mem_Zero, mem_Branch, mem_target, mem_alu_result, mem_busB, mem_Rw,
           mem_RegWr, mem_MemWr, mem_MemtoReg,
    input  PCSrc, pc_target, fwd_mem_data, fwd_mem_RegWr, wb_alu_result,
           wb_mem_data, wb_Rw, wb_RegWr, wb_MemtoReg, mem_err
  );
  modport slave (
    input  mem_Zero, mem_Branch, mem_target, mem_alu_result, mem_busB, mem_Rw,
           mem_RegWr, mem_MemWr, mem_MemtoReg,
    output PCSrc, pc_target, fwd_mem_data, fwd_mem_RegWr, wb_alu_result,
           wb_mem_data, wb_Rw, wb_RegWr, wb_MemtoReg, mem_err
  );
endinterface

// File: rtl/mem_stage_data_mem.sv
// Word-wide data memory: asynchronous read, synchronous write, enable gated by the parent.
module data_mem
  import pipe_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);
  logic [WORD_W-1:0] r_mem [2**ADDR_W];

  // Read-before-write falls out of the async read sampling the pre-edge contents.
  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end
endmodule

// File: rtl/mem_stage.sv
// MEM stage: data memory access, beq resolution, misalignment tracking and the MEM/WB register.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              mem_Zero,
  input  logic              mem_Branch,
  input  logic [WORD_W-1:0] mem_target,
  input  logic [WORD_W-1:0] mem_alu_result,
  input  logic [WORD_W-1:0] mem_busB,
  input  logic [REG_W-1:0]  mem_Rw,
  input  logic              mem_RegWr,
  input  logic              mem_MemWr,
  input  logic              mem_MemtoReg,
  output logic              PCSrc,
  output logic [WORD_W-1:0] pc_target,
  output logic [WORD_W-1:0] fwd_mem_data,
  output logic              fwd_mem_RegWr,
  output logic [WORD_W-1:0] wb_alu_result,
  output logic [WORD_W-1:0] wb_mem_data,
  output logic [REG_W-1:0]  wb_Rw,
  output logic              wb_RegWr,
  output logic              wb_MemtoReg,
  output logic              mem_err
);
  mem_ctrl_t         w_ctrl;
  logic [ADDR_W-1:0] w_idx;
  logic [WORD_W-1:0] w_rdata;
  logic              w_mis, w_we, w_eff_regwr;

  logic [WORD_W-1:0] r_alu_result, r_mem_data;
  logic [REG_W-1:0]  r_rw;
  wb_ctrl_t          r_wb_ctrl;
  logic              r_err;

  assign w_ctrl = '{RegWr: mem_RegWr, MemWr: mem_MemWr,
                    MemtoReg: mem_MemtoReg, Branch: mem_Branch};

  // Upper address bits are dropped so accesses wrap modulo the memory size.
  assign w_idx       = mem_alu_result[ADDR_W+1:2];
  assign w_mis       = (w_ctrl.MemWr | w_ctrl.MemtoReg) & (mem_alu_result[1:0] != 2'b00);
  assign w_we        = w_ctrl.MemWr & ~w_mis & ~Reset;
  assign w_eff_regwr = w_ctrl.RegWr & (mem_Rw != '0) & ~(w_mis & w_ctrl.MemtoReg);

  assign PCSrc         = w_ctrl.Branch & mem_Zero;
  assign pc_target     = mem_target;
  assign fwd_mem_data  = mem_alu_result;
  assign fwd_mem_RegWr = w_eff_regwr;

  data_mem #(.ADDR_W(ADDR_W)) u_dmem (
    .i_clk   (Clk),
    .i_we    (w_we),
    .i_addr  (w_idx),
    .i_wdata (mem_busB),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_alu_result <= '0;
      r_mem_data   <= '0;
      r_rw         <= '0;
      r_wb_ctrl    <= '0;
      r_err        <= 1'b0;
    end else begin
      r_alu_result <= mem_alu_result;
      r_mem_data   <= w_rdata;
      r_rw         <= mem_Rw;
      r_wb_ctrl    <= '{RegWr: w_eff_regwr, MemtoReg: w_ctrl.MemtoReg};
      if (w_mis) r_err <= 1'b1;
    end
  end

  assign wb_alu_result = r_alu_result;
  assign wb_mem_data   = r_mem_data;
  assign wb_Rw         = r_rw;
  assign wb_RegWr      = r_wb_ctrl.RegWr;
  assign wb_MemtoReg   = r_wb_ctrl.MemtoReg;
  assign mem_err       = r_err;
endmodule
